// File: rtl/riscv_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among NB_REQ requesters.
// A granted request is latched, issued to the FPU (or answered locally for
// NOP/illegal commands), and the response is returned as a one-cycle pulse
// to the owning requester on a broadcast result bus.
module riscv_fpu_arbiter #(
    parameter int unsigned NB_REQ = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NB_REQ-1:0]        req_i,
    output logic [NB_REQ-1:0]        gnt_o,
    input  logic [NB_REQ*4-1:0]      cmd_i,
    input  logic [NB_REQ*3-1:0]      rm_i,
    input  logic [NB_REQ*DATA_W-1:0] op_a_i,
    input  logic [NB_REQ*DATA_W-1:0] op_b_i,
    input  logic [NB_REQ*DATA_W-1:0] op_c_i,
    output logic [NB_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]        result_o,
    output logic [4:0]               fflags_o,
    output logic                     fpu_start_o,
    output logic [3:0]               fpu_cmd_o,
    output logic [2:0]               fpu_rm_o,
    output logic [DATA_W-1:0]        fpu_op_a_o,
    output logic [DATA_W-1:0]        fpu_op_b_o,
    output logic [DATA_W-1:0]        fpu_op_c_o,
    input  logic                     fpu_ready_i,
    input  logic                     fpu_valid_i,
    input  logic [DATA_W-1:0]        fpu_result_i,
    input  logic [4:0]               fpu_fflags_i,
    output logic                     busy_o
);

    localparam int unsigned IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned SUM_W  = IDX_W + 1;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned FLAG_W = 5;
    localparam logic [FLAG_W-1:0] FLAG_NV = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner_q;

    logic               found_c;
    logic [IDX_W-1:0]   owner_c;
    logic [IDX_W-1:0]   next_ptr_c;
    logic [SUM_W-1:0]   sum_c;
    logic [SUM_W-1:0]   nxt_c;
    logic [NB_REQ-1:0]  onehot_c;
    logic [CMD_W-1:0]   cmd_sel_c;
    logic [RM_W-1:0]    rm_sel_c;
    logic [DATA_W-1:0]  op_a_sel_c;
    logic [DATA_W-1:0]  op_b_sel_c;
    logic [DATA_W-1:0]  op_c_sel_c;
    logic               issue_c;
    logic               illegal_c;

    // Round-robin search: first set request at or above rr_ptr, wrapping.
    always_comb begin
        found_c    = 1'b0;
        owner_c    = '0;
        next_ptr_c = '0;
        sum_c      = '0;
        nxt_c      = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            sum_c = SUM_W'(rr_ptr) + SUM_W'(i);
            if (sum_c >= SUM_W'(NB_REQ)) begin
                sum_c = sum_c - SUM_W'(NB_REQ);
            end
            if (!found_c && req_i[IDX_W'(sum_c)]) begin
                found_c = 1'b1;
                owner_c = IDX_W'(sum_c);
                nxt_c   = sum_c + SUM_W'(1);
                if (nxt_c >= SUM_W'(NB_REQ)) begin
                    nxt_c = '0;
                end
                next_ptr_c = IDX_W'(nxt_c);
            end
        end
    end

    // Select the candidate owner's command fields and classify the command.
    always_comb begin
        onehot_c   = NB_REQ'(1) << owner_c;
        cmd_sel_c  = cmd_i[owner_c*CMD_W +: CMD_W];
        rm_sel_c   = rm_i[owner_c*RM_W +: RM_W];
        op_a_sel_c = op_a_i[owner_c*DATA_W +: DATA_W];
        op_b_sel_c = op_b_i[owner_c*DATA_W +: DATA_W];
        op_c_sel_c = op_c_i[owner_c*DATA_W +: DATA_W];
        issue_c    = (cmd_sel_c <= 4'h6) || ((cmd_sel_c >= 4'h8) && (cmd_sel_c <= 4'hB));
        illegal_c  = (cmd_sel_c >= 4'hC);
    end

    // Grant is combinational and only offered while idle and out of reset.
    always_comb begin
        gnt_o = '0;
        if (!rst && (state == S_IDLE) && found_c) begin
            gnt_o = onehot_c;
        end
    end

    // Arbiter FSM with registered issue bus, response and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner_q     <= '0;
            rvalid_o    <= '0;
            result_o    <= '0;
            fflags_o    <= '0;
            fpu_start_o <= 1'b0;
            fpu_cmd_o   <= '0;
            fpu_rm_o    <= '0;
            fpu_op_a_o  <= '0;
            fpu_op_b_o  <= '0;
            fpu_op_c_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found_c) begin
                        owner_q    <= owner_c;
                        rr_ptr     <= next_ptr_c;
                        fpu_cmd_o  <= cmd_sel_c;
                        fpu_rm_o   <= rm_sel_c;
                        fpu_op_a_o <= op_a_sel_c;
                        fpu_op_b_o <= op_b_sel_c;
                        fpu_op_c_o <= op_c_sel_c;
                        busy_o     <= 1'b1;
                        if (issue_c) begin
                            state       <= S_ISSUE;
                            fpu_start_o <= 1'b1;
                        end else begin
                            // NOP and reserved commands are answered locally.
                            state    <= S_RESP;
                            rvalid_o <= onehot_c;
                            result_o <= '0;
                            fflags_o <= illegal_c ? FLAG_NV : '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (fpu_ready_i) begin
                        state       <= S_WAIT;
                        fpu_start_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (fpu_valid_i) begin
                        state    <= S_RESP;
                        result_o <= fpu_result_i;
                        fflags_o <= fpu_fflags_i;
                        rvalid_o <= NB_REQ'(1) << owner_q;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    rvalid_o <= '0;
                    busy_o   <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    rvalid_o    <= '0;
                    fpu_start_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fpu_arbiter.sv
// Directed self-checking bench for riscv_fpu_arbiter.
module tb_riscv_fpu_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned DW = 32;

    logic             clk;
    logic             rst;
    logic [NB-1:0]    req;
    logic [NB-1:0]    gnt;
    logic [NB*4-1:0]  cmd;
    logic [NB*3-1:0]  rm;
    logic [NB*DW-1:0] op_a;
    logic [NB*DW-1:0] op_b;
    logic [NB*DW-1:0] op_c;
    logic [NB-1:0]    rvalid;
    logic [DW-1:0]    result;
    logic [4:0]       fflags;
    logic             fpu_start;
    logic [3:0]       fpu_cmd;
    logic [2:0]       fpu_rm;
    logic [DW-1:0]    fpu_op_a;
    logic [DW-1:0]    fpu_op_b;
    logic [DW-1:0]    fpu_op_c;
    logic             fpu_ready;
    logic             fpu_valid;
    logic [DW-1:0]    fpu_result;
    logic [4:0]       fpu_fflags;
    logic             busy;

    int checks;
    int errors;

    riscv_fpu_arbiter #(.NB_REQ(NB), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .gnt_o        (gnt),
        .cmd_i        (cmd),
        .rm_i         (rm),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .op_c_i       (op_c),
        .rvalid_o     (rvalid),
        .result_o     (result),
        .fflags_o     (fflags),
        .fpu_start_o  (fpu_start),
        .fpu_cmd_o    (fpu_cmd),
        .fpu_rm_o     (fpu_rm),
        .fpu_op_a_o   (fpu_op_a),
        .fpu_op_b_o   (fpu_op_b),
        .fpu_op_c_o   (fpu_op_c),
        .fpu_ready_i  (fpu_ready),
        .fpu_valid_i  (fpu_valid),
        .fpu_result_i (fpu_result),
        .fpu_fflags_i (fpu_fflags),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Move to the drive point of the next cycle.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Load one requester's command slot.
    task automatic set_req(input int idx, input logic [3:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        cmd[idx*4 +: 4]   = c;
        rm[idx*3 +: 3]    = 3'b000;
        op_a[idx*DW +: DW] = a;
        op_b[idx*DW +: DW] = b;
        op_c[idx*DW +: DW] = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        checks++; if ({fpu_start, fpu_cmd, fpu_op_a} !== 37'd0) begin errors++; $display("FAIL reset_fpu_bus: got start=%b cmd=%h a=%h expected zeros", fpu_start, fpu_cmd, fpu_op_a); end
        checks++; if ({result, fflags} !== 37'd0) begin errors++; $display("FAIL reset_result: got %h/%b expected 0/0", result, fflags); end
        next_cycle;
        rst = 1'b0;
        req = '0;
        next_cycle;
    endtask

    task automatic test_add;
        set_req(0, 4'h0, 32'h3f800000, 32'h40000000);
        req = 4'b0001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL add_gnt: got %b expected 0001", gnt); end
        next_cycle;
        req = '0;
        fpu_ready = 1'b1;
        @(negedge clk);
        checks++; if (fpu_start !== 1'b1) begin errors++; $display("FAIL add_start: got %b expected 1", fpu_start); end
        checks++; if ({fpu_cmd, fpu_op_a, fpu_op_b} !== {4'h0, 32'h3f800000, 32'h40000000}) begin errors++; $display("FAIL add_issue_bus: got cmd=%h a=%h b=%h", fpu_cmd, fpu_op_a, fpu_op_b); end
        checks++; if ({busy, gnt} !== 5'b1_0000) begin errors++; $display("FAIL add_busy_gnt: got busy=%b gnt=%b expected 1/0000", busy, gnt); end
        next_cycle;
        fpu_ready = 1'b0;
        @(negedge clk);
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL add_start_drop: got %b expected 0", fpu_start); end
        next_cycle;
        next_cycle;
        fpu_valid  = 1'b1;
        fpu_result = 32'h40400000;
        fpu_fflags = 5'b00000;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL add_rvalid_early: got %b expected 0000", rvalid); end
        next_cycle;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL add_rvalid: got %b expected 0001", rvalid); end
        checks++; if ({result, fflags} !== {32'h40400000, 5'b00000}) begin errors++; $display("FAIL add_result: got %h/%b expected 40400000/00000", result, fflags); end
        next_cycle;
        @(negedge clk);
        checks++; if ({rvalid, busy} !== 5'b0000_0) begin errors++; $display("FAIL add_done: got rvalid=%b busy=%b expected 0000/0", rvalid, busy); end
        checks++; if (result !== 32'h40400000) begin errors++; $display("FAIL add_result_hold: got %h expected 40400000", result); end
        next_cycle;
    endtask

    task automatic test_nop;
        set_req(2, 4'h7, 32'h11111111, 32'h22222222);
        req = 4'b0100;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL nop_gnt: got %b expected 0100", gnt); end
        next_cycle;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL nop_rvalid: got %b expected 0100", rvalid); end
        checks++; if ({result, fflags} !== 37'd0) begin errors++; $display("FAIL nop_result: got %h/%b expected 0/0", result, fflags); end
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL nop_start: got %b expected 0", fpu_start); end
        next_cycle;
        @(negedge clk);
        checks++; if ({rvalid, fpu_start} !== 5'b0000_0) begin errors++; $display("FAIL nop_after: got rvalid=%b start=%b expected 0000/0", rvalid, fpu_start); end
        next_cycle;
    endtask

    task automatic test_illegal;
        set_req(1, 4'hE, 32'h33333333, 32'h44444444);
        req = 4'b0010;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ill_gnt: got %b expected 0010", gnt); end
        next_cycle;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL ill_rvalid: got %b expected 0010", rvalid); end
        checks++; if ({result, fflags} !== {32'h0, 5'b10000}) begin errors++; $display("FAIL ill_result: got %h/%b expected 0/10000", result, fflags); end
        checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL ill_start: got %b expected 0", fpu_start); end
        next_cycle;
        @(negedge clk);
        checks++; if ({rvalid, fflags} !== {4'b0000, 5'b10000}) begin errors++; $display("FAIL ill_hold: got rvalid=%b fflags=%b expected 0000/10000", rvalid, fflags); end
        next_cycle;
    endtask

    task automatic test_round_robin;
        logic [NB-1:0] e;
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 4'h7, 32'(i), 32'(i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = NB'(1) << (k % 4);
            @(negedge clk);
            checks++; if (gnt !== e) begin errors++; $display("FAIL rr_gnt_%0d: got %b expected %b", k, gnt, e); end
            next_cycle;
            @(negedge clk);
            checks++; if ({gnt, rvalid} !== {4'b0000, e}) begin errors++; $display("FAIL rr_resp_%0d: got gnt=%b rvalid=%b expected 0000/%b", k, gnt, rvalid, e); end
            next_cycle;
        end
        // Pointer now at 1: sparse request must wrap past 1,2 to 3, then 0.
        req = 4'b1001;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rr_sparse_a: got %b expected 1000", gnt); end
        next_cycle;
        next_cycle;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_sparse_b: got %b expected 0001", gnt); end
        next_cycle;
        req = '0;
        next_cycle;
    endtask

    task automatic test_ready_stall;
        set_req(0, 4'h1, 32'h40400000, 32'h3f800000);
        req = 4'b0001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_gnt: got %b expected 0001", gnt); end
        next_cycle;
        req = '0;
        for (int c = 1; c <= 5; c++) begin
            fpu_ready  = (c == 5);
            fpu_valid  = (c == 2);
            fpu_result = (c == 2) ? 32'hdeadbeef : 32'h0;
            @(negedge clk);
            checks++; if ({fpu_start, fpu_cmd} !== {1'b1, 4'h1}) begin errors++; $display("FAIL stall_issue_c%0d: got start=%b cmd=%h expected 1/1", c, fpu_start, fpu_cmd); end
            next_cycle;
        end
        fpu_ready  = 1'b0;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        @(negedge clk);
        checks++; if ({fpu_start, rvalid} !== 5'b0_0000) begin errors++; $display("FAIL stall_single_issue: got start=%b rvalid=%b expected 0/0000", fpu_start, rvalid); end
        next_cycle;
        fpu_valid  = 1'b1;
        fpu_result = 32'h40000000;
        fpu_fflags = 5'b00001;
        next_cycle;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        fpu_fflags = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL stall_rvalid: got %b expected 0001", rvalid); end
        checks++; if ({result, fflags} !== {32'h40000000, 5'b00001}) begin errors++; $display("FAIL stall_result: got %h/%b expected 40000000/00001", result, fflags); end
        next_cycle;
    endtask

    task automatic test_reset_mid;
        set_req(2, 4'h0, 32'h3f800000, 32'h3f800000);
        req = 4'b0100;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt: got %b expected 0100", gnt); end
        next_cycle;
        req = '0;
        fpu_ready = 1'b1;
        next_cycle;
        fpu_ready = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, fpu_start, rvalid} !== 6'd0) begin errors++; $display("FAIL rmid_status: got busy=%b start=%b rvalid=%b expected zeros", busy, fpu_start, rvalid); end
        checks++; if ({result, fflags, fpu_op_a} !== 69'd0) begin errors++; $display("FAIL rmid_buses: got result=%h fflags=%b a=%h expected zeros", result, fflags, fpu_op_a); end
        next_cycle;
        rst = 1'b0;
        fpu_valid  = 1'b1;
        fpu_result = 32'h12345678;
        @(negedge clk);
        checks++; if ({rvalid, busy} !== 5'd0) begin errors++; $display("FAIL rmid_late_valid: got rvalid=%b busy=%b expected 0000/0", rvalid, busy); end
        next_cycle;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        @(negedge clk);
        checks++; if ({rvalid, result} !== 36'd0) begin errors++; $display("FAIL rmid_no_resp: got rvalid=%b result=%h expected 0000/0", rvalid, result); end
        set_req(0, 4'h7, 32'h0, 32'h0);
        next_cycle;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_next_gnt: got %b expected 0001", gnt); end
        next_cycle;
        req = '0;
        @(negedge clk);
        checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL rmid_next_rvalid: got %b expected 0001", rvalid); end
        next_cycle;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req        = '0;
        cmd        = '0;
        rm         = '0;
        op_a       = '0;
        op_b       = '0;
        op_c       = '0;
        fpu_ready  = 1'b0;
        fpu_valid  = 1'b0;
        fpu_result = '0;
        fpu_fflags = '0;
        #1;
        test_reset;
        test_add;
        test_nop;
        test_illegal;
        test_round_robin;
        test_ready_stall;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
